// File: rtl/gf2_poly_reducer.sv
// Digit-serial reduction of a 2M-bit carry-less product modulo F(x) = x^M + POLY(x).
// Each REDUCE cycle clears the top DIGIT coefficients of the working accumulator.
module gf2_poly_reducer #(
  parameter int             M     = 1024,
  parameter logic [M-1:0]   POLY  = 1024'h80043,
  parameter int             DIGIT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2*M-1:0]   in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [M-1:0]     out_data,
  output logic             busy,
  output logic [1:0]       fsm_state
);

  localparam int D  = M / DIGIT;
  localparam int CW = $clog2(D) + 1;
  localparam logic [CW-1:0]  LAST   = CW'(D - 1);
  localparam logic [2*M-1:0] F_FULL = {{(M-1){1'b0}}, 1'b1, POLY};

  if (M % DIGIT != 0) begin : g_bad_digit
    $error("gf2_poly_reducer: M must be a multiple of DIGIT");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REDUCE = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t           state;
  logic [2*M-1:0]   acc;
  logic [2*M-1:0]   acc_red;
  logic [CW-1:0]    cnt;

  // The accumulator is shifted left by DIGIT after every cycle, so the digit
  // being eliminated always sits at the fixed top positions [2M-1 -: DIGIT].
  // Coefficient p of the product lives at p + cnt*DIGIT during REDUCE.
  always_comb begin
    acc_red = acc;
    for (int j = 0; j < DIGIT; j++) begin
      if (acc_red[2*M-1-j]) begin
        acc_red = acc_red ^ (F_FULL << (M - 1 - j));
      end
    end
  end

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid is never withdrawn before that edge, and data is held
  // stable while valid is high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            acc      <= in_data;
            cnt      <= '0;
            state    <= REDUCE;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        REDUCE: begin
          acc <= acc_red << DIGIT;
          if (cnt == LAST) begin
            // After D-1 earlier shifts the residue occupies [2M-1-DIGIT -: M].
            out_data  <= acc_red[2*M-1-DIGIT -: M];
            out_valid <= 1'b1;
            cnt       <= '0;
            state     <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
          cnt       <= '0;
        end
      endcase
    end
  end

  assign fsm_state = state;

  a_cnt_bound: assert property (@(posedge clk) disable iff (!rst)
    (state == REDUCE) |-> (cnt <= LAST));

  a_done_hold: assert property (@(posedge clk) disable iff (!rst)
    (state == DONE && !out_ready) |=> (state == DONE && out_valid && $stable(out_data)));

  a_ready_idle: assert property (@(posedge clk) disable iff (!rst)
    in_ready == (state == IDLE));

endmodule

// File: tb/tb_gf2_poly_reducer.sv
// Bench for gf2_poly_reducer: a small AES-field instance with hand-computed
// vectors and a default-size instance checked against a clmul/mod model.
module tb_gf2_poly_reducer;

  localparam int W  = 1024;
  localparam int SM = 8;
  localparam int SD = 4;
  localparam logic [SM-1:0] S_POLY = 8'h1B;
  localparam int LM = 1024;
  localparam int LD = 64;
  localparam logic [LM-1:0] L_POLY = 1024'h80043;

  logic clk = 1'b0;
  logic rst = 1'b0;
  longint cyc = 0;

  logic            s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_busy;
  logic [2*SM-1:0] s_in_data;
  logic [SM-1:0]   s_out_data;
  logic [1:0]      s_state;

  logic            l_in_valid, l_in_ready, l_out_valid, l_out_ready, l_busy;
  logic [2*LM-1:0] l_in_data;
  logic [LM-1:0]   l_out_data;
  logic [1:0]      l_state;

  int checks = 0;
  int errors = 0;
  logic [SM-1:0] exp_s_q[$];
  logic [LM-1:0] exp_l_q[$];
  bit     spacing_en = 1'b0;
  longint l_last = -1;

  gf2_poly_reducer #(.M(SM), .POLY(S_POLY), .DIGIT(SD)) u_small (
    .clk(clk), .rst(rst),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
    .busy(s_busy), .fsm_state(s_state)
  );

  gf2_poly_reducer #(.M(LM), .POLY(L_POLY), .DIGIT(LD)) u_large (
    .clk(clk), .rst(rst),
    .in_valid(l_in_valid), .in_ready(l_in_ready), .in_data(l_in_data),
    .out_valid(l_out_valid), .out_ready(l_out_ready), .out_data(l_out_data),
    .busy(l_busy), .fsm_state(l_state)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // reference model
  function automatic logic [2*LM-1:0] clmul(input logic [LM-1:0] a, input logic [LM-1:0] b);
    logic [2*LM-1:0] p;
    p = '0;
    for (int i = 0; i < LM; i++) begin
      if (b[i]) p = p ^ ({{LM{1'b0}}, a} << i);
    end
    return p;
  endfunction

  function automatic logic [LM-1:0] mod_l(input logic [2*LM-1:0] p);
    logic [2*LM-1:0] f;
    logic [2*LM-1:0] r;
    f = {{(LM-1){1'b0}}, 1'b1, L_POLY};
    r = p;
    for (int k = 2*LM-1; k >= LM; k--) begin
      if (r[k]) r = r ^ (f << (k - LM));
    end
    return r[LM-1:0];
  endfunction

  task automatic gen(output logic [LM-1:0] a);
    for (int w = 0; w < LM/16; w++) a[16*w +: 16] = 16'($urandom_range(16'hFFFF, 0));
  endtask

  // scoreboard monitors
  always @(negedge clk) begin
    if (rst && s_out_valid && s_out_ready) begin
      if (exp_s_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL s_unexpected: got %0h expected no output", s_out_data);
      end else begin
        check("s_out_data", W'(s_out_data), W'(exp_s_q.pop_front()));
      end
    end
  end

  always @(negedge clk) begin
    if (rst && l_out_valid && l_out_ready) begin
      if (exp_l_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL l_unexpected: got %0h expected no output", l_out_data);
      end else begin
        check("l_out_data", W'(l_out_data), W'(exp_l_q.pop_front()));
      end
      if (spacing_en) begin
        if (l_last >= 0) check("l_spacing", W'(cyc - l_last), W'(18));
        l_last = cyc;
      end
    end
  end

  // driver tasks
  task automatic send_s(input logic [2*SM-1:0] d, input logic [SM-1:0] e);
    int n;
    s_in_valid = 1'b1;
    s_in_data  = d;
    n = 0;
    @(negedge clk);
    while (!s_in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!s_in_ready) begin
      checks++; errors++;
      $display("FAIL s_accept_timeout: in_ready 0 expected 1");
      s_in_valid = 1'b0;
      return;
    end
    exp_s_q.push_back(e);
    @(posedge clk); #1;
    s_in_valid = 1'b0;
  endtask

  task automatic send_l(input logic [2*LM-1:0] d, input logic [LM-1:0] e, input bit push);
    int n;
    l_in_valid = 1'b1;
    l_in_data  = d;
    n = 0;
    @(negedge clk);
    while (!l_in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!l_in_ready) begin
      checks++; errors++;
      $display("FAIL l_accept_timeout: in_ready 0 expected 1");
      l_in_valid = 1'b0;
      return;
    end
    if (push) exp_l_q.push_back(e);
    @(posedge clk); #1;
    l_in_valid = 1'b0;
  endtask

  // Called right after the acceptance edge; returns edges until out_valid is seen.
  task automatic wait_s_valid(output int lat);
    lat = 0;
    @(negedge clk);
    while (!s_out_valid && lat < 100) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic wait_l_valid(output int lat);
    lat = 0;
    @(negedge clk);
    while (!l_out_valid && lat < 100) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  logic [2*SM-1:0] vin  [6] = '{16'h2B79, 16'h0000, 16'h00A5, 16'hFFFF, 16'h0100, 16'h8000};
  logic [SM-1:0]   vout [6] = '{8'hC1,    8'h00,    8'hA5,    8'h35,    8'h1B,    8'h2F};

  initial begin
    logic [LM-1:0]   a, b;
    logic [2*LM-1:0] p;
    int lat;
    int n;

    s_in_valid = 1'b0; s_in_data = '0; s_out_ready = 1'b1;
    l_in_valid = 1'b0; l_in_data = '0; l_out_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check("rst_s_in_ready",  W'(s_in_ready),  W'(1'b1));
    check("rst_s_out_valid", W'(s_out_valid), W'(1'b0));
    check("rst_s_busy",      W'(s_busy),      W'(1'b0));
    check("rst_s_out_data",  W'(s_out_data),  W'(8'h00));
    check("rst_s_state",     W'(s_state),     W'(2'd0));
    check("rst_l_in_ready",  W'(l_in_ready),  W'(1'b1));
    check("rst_l_out_valid", W'(l_out_valid), W'(1'b0));
    rst = 1'b1;
    @(posedge clk); #1;

    // directed small-field vectors, latency D=2 each
    for (int i = 0; i < 6; i++) begin
      send_s(vin[i], vout[i]);
      wait_s_valid(lat);
      check("s_latency", W'(lat), W'(2));
      @(posedge clk); #1;
    end

    // back-pressure: result held, new input refused while in DONE
    s_out_ready = 1'b0;
    send_s(16'h2B79, 8'hC1);
    wait_s_valid(lat);
    check("s_bp_latency", W'(lat), W'(2));
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      s_in_valid = (i == 3);
      s_in_data  = 16'h00A5;
      @(negedge clk);
      check("s_bp_out_data",  W'(s_out_data),  W'(8'hC1));
      check("s_bp_out_valid", W'(s_out_valid), W'(1'b1));
      check("s_bp_in_ready",  W'(s_in_ready),  W'(1'b0));
      check("s_bp_busy",      W'(s_busy),      W'(1'b1));
    end
    @(posedge clk); #1;
    s_in_valid  = 1'b0;
    s_out_ready = 1'b1;
    @(posedge clk); #1;
    check("s_bp_idle_in_ready",  W'(s_in_ready),  W'(1'b1));
    check("s_bp_idle_busy",      W'(s_busy),      W'(1'b0));
    check("s_bp_idle_out_valid", W'(s_out_valid), W'(1'b0));
    repeat (20) @(posedge clk);
    #1;
    check("s_bp_no_extra", W'(exp_s_q.size()), W'(0));

    // reset while the large instance is at cnt==1
    gen(a); gen(b);
    p = clmul(a, b);
    send_l(p, '0, 1'b0);
    @(posedge clk); #2;
    check("l_mid_in_ready_pre", W'(l_in_ready), W'(1'b0));
    rst = 1'b0;
    #1;
    check("l_abort_out_valid", W'(l_out_valid), W'(1'b0));
    check("l_abort_in_ready",  W'(l_in_ready),  W'(1'b1));
    check("l_abort_busy",      W'(l_busy),      W'(1'b0));
    check("l_abort_state",     W'(l_state),     W'(2'd0));
    rst = 1'b1;
    @(posedge clk); #1;
    gen(a); gen(b);
    p = clmul(a, b);
    send_l(p, mod_l(p), 1'b1);
    wait_l_valid(lat);
    check("l_latency", W'(lat), W'(16));
    @(posedge clk); #1;

    // 200 back-to-back products with spacing check
    spacing_en = 1'b1;
    l_last = -1;
    for (int i = 0; i < 200; i++) begin
      gen(a); gen(b);
      if (i == 0) begin
        a = '1; b = '1;
      end
      p = clmul(a, b);
      if (i == 1) p = '1;
      send_l(p, mod_l(p), 1'b1);
    end
    n = 0;
    while (exp_l_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("l_drain", W'(exp_l_q.size()), W'(0));
    spacing_en = 1'b0;
    check("s_drain", W'(exp_s_q.size()), W'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
